// File: rtl/key_pkg.sv
// key_pkg: FSM encoding, default timing constants and counter sizing
// shared by the key_pulse_gen button conditioner.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESS_DEB   = 3'd1,
    ST_HELD        = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_RELEASE_DEB = 3'd4
  } key_state_t;

  localparam int unsigned KEY_NUM_DEF       = 3;
  localparam int unsigned DEBOUNCE_DEF      = 2_000_000;
  localparam int unsigned REPEAT_DELAY_DEF  = 100_000_000;
  localparam int unsigned REPEAT_PERIOD_DEF = 20_000_000;

  // Repeat timers only widen the counter when auto-repeat is built.
  function automatic int unsigned cnt_w(
    input int unsigned deb,
    input int unsigned dly,
    input int unsigned per,
    input bit          rep
  );
    int unsigned m;
    m = deb;
    if (rep) begin
      if (dly > m) m = dly;
      if (per > m) m = per;
    end
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if: raw key inputs and conditioned command outputs
// of key_pulse_gen, with board-side (master) and block-side (slave) views.
interface key_pulse_gen_if
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM = KEY_NUM_DEF
);

  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_out;
  logic [KEY_NUM-1:0] key_level;
  logic               key_busy;

  modport master (
    output key_in,
    input  key_out,
    input  key_level,
    input  key_busy
  );

  modport slave (
    input  key_in,
    output key_out,
    output key_level,
    output key_busy
  );

endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key's 2-flop synchroniser, debounce FSM and counter.
// Hold-to-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic event_o,
  output logic level_o
);

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES,
    REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES, 1'b1);
  localparam logic [CW-1:0] DLY_LAST =
    CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] PER_LAST =
    CW'(REPEAT_PERIOD_CYCLES - 1);
`else
  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES,
    REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES, 1'b0);
`endif
  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          p;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
    end
  end

  assign p = ~sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    event_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (p) begin
          state_d = ST_PRESS_DEB;
          cnt_d   = '0;
        end
      end
      ST_PRESS_DEB: begin
        if (!p) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          event_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        // A release edge wins over a coincident repeat timeout.
        if (!p) begin
          state_d = ST_RELEASE_DEB;
          cnt_d   = '0;
`ifdef KEY_AUTO_REPEAT_EN
        end else if (cnt_q == DLY_LAST) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          event_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
`ifdef KEY_AUTO_REPEAT_EN
      ST_REPEAT: begin
        if (!p) begin
          state_d = ST_RELEASE_DEB;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          cnt_d   = '0;
          event_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      ST_RELEASE_DEB: begin
        if (p) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = (state_q != ST_IDLE) &&
                   (state_q != ST_PRESS_DEB);

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounced single-cycle key command pulses, serialised
// lowest-index first; auto-repeat enabled by KEY_AUTO_REPEAT_EN.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM              = KEY_NUM_DEF,
  parameter int unsigned DEBOUNCE_CYCLES      = DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY_CYCLES  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEF
) (
  input logic           mem_clk,
  input logic           rst_n,
  key_pulse_gen_if.slave bus
);

  logic [KEY_NUM-1:0] ev;
  logic [KEY_NUM-1:0] lvl;
  logic [KEY_NUM-1:0] grant;
  logic [KEY_NUM-1:0] pend_q, pend_d;
  logic [KEY_NUM-1:0] out_q;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
    ) u_ch (
      .clk_i  (mem_clk),
      .rst_ni (rst_n),
      .key_ni (bus.key_in[g]),
      .event_o(ev[g]),
      .level_o(lvl[g])
    );
  end

  // Isolate the lowest set pending bit.
  assign grant = pend_q & (~pend_q + KEY_NUM'(1));

  // A fresh event re-arms a bit being granted this cycle.
  assign pend_d = (pend_q & ~grant) | ev;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      out_q  <= '0;
    end else begin
      pend_q <= pend_d;
      out_q  <= grant;
    end
  end

  assign bus.key_out   = out_q;
  assign bus.key_level = lvl;
  assign bus.key_busy  = |pend_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed + random stimulus for key_pulse_gen, checked
// every cycle against a streak/age model; honours KEY_AUTO_REPEAT_EN.
`timescale 1ns/1ps
module tb_key_pulse_gen;

  localparam int D = 8;
  localparam int R = 40;
  localparam int P = 10;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   pcnt [N];

  key_pulse_gen_if #(.KEY_NUM(N)) bus ();

  key_pulse_gen #(
    .KEY_NUM             (N),
    .DEBOUNCE_CYCLES     (D),
    .REPEAT_DELAY_CYCLES (R),
    .REPEAT_PERIOD_CYCLES(P)
  ) dut (
    .mem_clk(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: p is the key sampled two edges ago; the level flips after
  // D+1 consecutive disagreeing edges; repeats count edges of steady hold.
  bit         m_s1 [N];
  bit         m_s2 [N];
  bit         m_lvl [N];
  int         m_streak [N];
  int         m_age [N];
  bit         m_first [N];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_out;
  logic [N-1:0] m_ev;
  logic [N-1:0] m_gr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_s1[k] = 1'b1;
        m_s2[k] = 1'b1;
        m_lvl[k] = 1'b0;
        m_streak[k] = 0;
        m_age[k] = 0;
        m_first[k] = 1'b1;
      end
      m_pend = '0;
      m_out = '0;
    end else begin
      m_ev = '0;
      for (int k = 0; k < N; k++) begin
        bit p;
        p = !m_s2[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = bus.key_in[k];
        if (p != m_lvl[k]) begin
          m_streak[k]++;
          if (m_streak[k] == D + 1) begin
            m_lvl[k] = p;
            m_streak[k] = 0;
            if (p) begin
              m_ev[k] = 1'b1;
              m_age[k] = 0;
              m_first[k] = 1'b1;
            end
          end
        end else begin
          if (m_lvl[k]) begin
            if (m_streak[k] > 0) begin
              m_age[k] = 0;
              m_first[k] = 1'b1;
            end else begin
`ifdef KEY_AUTO_REPEAT_EN
              m_age[k]++;
              if (m_age[k] == (m_first[k] ? R : P)) begin
                m_ev[k] = 1'b1;
                m_age[k] = 0;
                m_first[k] = 1'b0;
              end
`endif
            end
          end
          m_streak[k] = 0;
        end
      end
      m_gr = '0;
      for (int k = N - 1; k >= 0; k--)
        if (m_pend[k]) m_gr = '0 | (N'(1) << k);
      m_out = m_gr;
      m_pend = (m_pend & ~m_gr) | m_ev;
    end
  end

  logic [N-1:0] m_lvl_v;
  always_comb
    for (int k = 0; k < N; k++) m_lvl_v[k] = m_lvl[k];

  always @(negedge clk) begin
    checks += 3;
    if (bus.key_out !== m_out) begin
      failures++;
      $display("FAIL out cyc=%0d got=%b exp=%b", cyc, bus.key_out, m_out);
    end
    if (bus.key_level !== m_lvl_v) begin
      failures++;
      $display("FAIL level cyc=%0d got=%b exp=%b", cyc, bus.key_level, m_lvl_v);
    end
    if (bus.key_busy !== (|m_pend)) begin
      failures++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.key_busy, |m_pend);
    end
    for (int k = 0; k < N; k++)
      if (bus.key_out[k] === 1'b1) pcnt[k]++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step(1);
  endtask

  int e, r, base, rem [N];

  initial begin
    for (int k = 0; k < N; k++) pcnt[k] = 0;
    bus.key_in = '1;
    step(3);
    chk("rst_out", 32'(bus.key_out), 0);
    chk("rst_lvl", 32'(bus.key_level), 0);
    chk("rst_busy", 32'(bus.key_busy), 0);
    rst_n = 1'b1;
    step(5);

    // clean press on key 0
    bus.key_in[0] = 1'b0;
    e = cyc + 1;
    goto(e + D + 1);
    chk("c1_lvl_pre", 32'(bus.key_level[0]), 0);
    goto(e + D + 2);
    chk("c1_lvl", 32'(bus.key_level[0]), 1);
    chk("c1_busy", 32'(bus.key_busy), 1);
    chk("c1_out_pre", 32'(bus.key_out), 0);
    goto(e + D + 3);
    chk("c1_out", 32'(bus.key_out), 32'b001);
    goto(e + D + 4);
    chk("c1_out_post", 32'(bus.key_out), 0);
    goto(e + 19);
    bus.key_in[0] = 1'b1;
    goto(e + 29);
    chk("c1_rel_pre", 32'(bus.key_level[0]), 1);
    goto(e + 30);
    chk("c1_rel", 32'(bus.key_level[0]), 0);
    chk("c1_count", 32'(pcnt[0]), 1);
    step(5);

    // bounce rejection on key 1
    base = pcnt[1];
    for (int i = 0; i < 6; i++) begin
      bus.key_in[1] = 1'b0;
      step(5);
      bus.key_in[1] = 1'b1;
      step(1);
    end
    step(15);
    chk("c2_count", 32'(pcnt[1] - base), 0);
    chk("c2_lvl", 32'(bus.key_level), 0);

    // simultaneous press of keys 1 and 2
    bus.key_in[2:1] = 2'b00;
    e = cyc + 1;
    goto(e + D + 2);
    chk("c3_busy0", 32'(bus.key_busy), 1);
    goto(e + D + 3);
    chk("c3_out1", 32'(bus.key_out), 32'b010);
    chk("c3_busy1", 32'(bus.key_busy), 1);
    goto(e + D + 4);
    chk("c3_out2", 32'(bus.key_out), 32'b100);
    chk("c3_busy2", 32'(bus.key_busy), 0);
    goto(e + 15);
    bus.key_in[2:1] = 2'b11;
    step(20);

    // long hold on key 2
    base = pcnt[2];
    bus.key_in[2] = 1'b0;
    e = cyc + 1;
`ifdef KEY_AUTO_REPEAT_EN
    goto(e + D + 3 + R);
    chk("c4_rep1", 32'(bus.key_out), 32'b100);
`endif
    goto(e + 99);
    bus.key_in[2] = 1'b1;
    goto(e + 130);
`ifdef KEY_AUTO_REPEAT_EN
    chk("c4_count", 32'(pcnt[2] - base), 7);
`else
    chk("c4_count", 32'(pcnt[2] - base), 1);
`endif

    // random bouncing and holding on all keys
    for (int k = 0; k < N; k++) rem[k] = 1;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < N; k++) begin
        rem[k]--;
        if (rem[k] <= 0) begin
          bus.key_in[k] = ~bus.key_in[k];
          rem[k] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(20, 70)) :
                   int'($urandom_range(1, 10));
        end
      end
      step(1);
    end
    bus.key_in = '1;
    step(40);
    chk("rnd_idle", 32'(bus.key_busy), 0);

    // reset in the middle of a debounce
    bus.key_in[0] = 1'b0;
    e = cyc + 1;
    goto(e + 4);
    rst_n = 1'b0;
    step(1);
    chk("c6_out", 32'(bus.key_out), 0);
    chk("c6_lvl", 32'(bus.key_level), 0);
    chk("c6_busy", 32'(bus.key_busy), 0);
    step(2);
    rst_n = 1'b1;
    r = cyc;
    base = pcnt[0];
    goto(r + D + 3);
    chk("c6_pre", 32'(bus.key_out), 0);
    goto(r + D + 4);
    chk("c6_pulse", 32'(bus.key_out), 32'b001);
    goto(r + 20);
    bus.key_in[0] = 1'b1;
    step(20);
    chk("c6_count", 32'(pcnt[0] - base), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Conditions the three raw push-buttons on the board into the single-cycle `key_out` command pulses consumed by the image rotation/transform stage, in the `mem_clk` domain. The block has three parts:
- a two-flop synchroniser per key,
- a debounce state machine per key, with optional hold-to-repeat,
- an output serialiser that guarantees at most one `key_out` bit is high per cycle.

This stops the downstream priority chains from ever seeing simultaneous commands.

## Interface
Parameters:
- `KEY_NUM`, 3, number of buttons.
- `DEBOUNCE_CYCLES`, 2_000_000, consecutive stable cycles needed to accept a press or release (10 ms at 200 MHz).
- `REPEAT_DELAY_CYCLES`, 100_000_000, hold time before the first auto-repeat pulse.
- `REPEAT_PERIOD_CYCLES`, 20_000_000, interval between later auto-repeat pulses.

Ports:
- `mem_clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_in`  in  KEY_NUM  raw buttons, asynchronous, active-low (0 = pressed).
- `key_out`  out  KEY_NUM  one-hot-or-zero command pulses, each one cycle wide.
- `key_level`  out  KEY_NUM  debounced level, 1 = held.
- `key_busy`  out  1  high while any pending pulse is still waiting to be issued.

## Operation
Synchroniser:
- Each `key_in` bit passes through 2 flops, both resetting to 1 (released).
- `p` denotes the inverted synchronised value (1 = pressed).

Per-key FSM states: IDLE, PRESS_DEB, HELD, REPEAT, RELEASE_DEB.
- IDLE: p=1 goes to PRESS_DEB with the counter cleared.
- PRESS_DEB: each cycle with p=1 increments the counter. p=0 returns to IDLE. When the counter reaches DEBOUNCE_CYCLES-1 while p=1, the FSM goes to HELD, raises a press event, sets `key_level`=1 and clears the counter.
- HELD: the counter runs.
  - At REPEAT_DELAY_CYCLES-1: repeat event, go to REPEAT, clear the counter.
  - p=0: go to RELEASE_DEB.
- REPEAT: at every REPEAT_PERIOD_CYCLES-1 there is a repeat event and the counter clears. p=0 goes to RELEASE_DEB.
- RELEASE_DEB: counts cycles with p=0.
  - p=1 returns to HELD with the counter cleared; the repeat delay restarts and no event is raised.
  - Reaching DEBOUNCE_CYCLES-1 with p=0 goes to IDLE and sets `key_level`=0. A release raises no event.

Counter:
- There is one counter per key.
- Its width is `$clog2` of the largest of the three cycle parameters. It never wraps.

Serialiser:
- An event sets `pending[i]`. An event that arrives while `pending[i]` is already set is dropped, so at most one outstanding event per key.
- Each cycle, the lowest-index set pending bit is driven registered onto `key_out` and cleared.
- If a new event and a clear for the same bit happen in the same cycle, the new event sets the bit again, so it is not lost.
- `key_busy` = |pending.

## Timing
- Reset values: `key_out`=0, `key_level`=0, `key_busy`=0, all FSMs in IDLE, counters 0, pending 0, synchronisers 1.
- Press latency: if `key_in` is low from mem_clk edge E and there is no contention, the press event comes at E+DEBOUNCE_CYCLES+2 and `key_out` is high for the single cycle after E+DEBOUNCE_CYCLES+3.
- `key_level` rises in the same cycle the pending bit sets, one cycle before `key_out`.
- Contention: each competing key with a lower index delays a pulse by one more cycle.
- Auto-repeat pulses follow the press pulse at REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES, each subject to the same serialiser delay.
- Reset asserted mid-operation clears everything immediately and drops pending pulses.
- A key still held when reset releases is treated as a new press: full debounce, then one pulse.

## Configuration
- Macro `KEY_AUTO_REPEAT_EN`.
- Defined: HELD and REPEAT behave as described under Operation.
- Undefined: HELD never times out, the REPEAT state and its logic are not built, and exactly one pulse is produced per debounced press. `REPEAT_DELAY_CYCLES` and `REPEAT_PERIOD_CYCLES` are ignored, and the counter width is `$clog2(DEBOUNCE_CYCLES)`.

## Structure
- Shared package `key_pkg` holds:
  - the FSM state encoding `key_state_t` (3 bits: IDLE=0, PRESS_DEB=1, HELD=2, REPEAT=3, RELEASE_DEB=4),
  - the default cycle-count constants.
- Sub-module `key_debounce_ch` holds the synchroniser, FSM and counter for one key, with outputs `event` and `level`. It is instantiated KEY_NUM times with a generate loop.
- The pending register and the lowest-index priority serialiser stay in the top level.

## Test plan
All cases run with DEBOUNCE_CYCLES=8, REPEAT_DELAY_CYCLES=40, REPEAT_PERIOD_CYCLES=10, and `KEY_AUTO_REPEAT_EN` defined unless stated otherwise.

1. Clean press: `key_in[0]` driven low at edge 10 and held for 20 cycles, then high. Expected: a single `key_out`=3'b001 in cycle 21, `key_level[0]`=1 from cycle 20, and `key_level[0]` back to 0 about 10 cycles after the release.
2. Bounce rejection: `key_in[1]` toggled low for 5 cycles and high for 1, repeated 6 times. Expected: `key_out` stays 0 and `key_level` stays 0.
3. Simultaneous press: keys 1 and 2 pressed on the same edge. Expected: `key_out`=3'b010 in one cycle and 3'b100 in the next; `key_busy` is high for exactly 1 cycle between them.
4. Auto-repeat: key 2 held for 100 cycles. Expected pulses at press, +40, +50, +60, …, +90; none after the release.
5. Repeat disabled: case 4 rebuilt without `KEY_AUTO_REPEAT_EN`. Expected: exactly one pulse.
6. Reset mid-debounce: `rst_n` pulled low 4 cycles into a press, key still held, `rst_n` released. Expected: all outputs 0 during reset, then one pulse DEBOUNCE_CYCLES+3 cycles after the reset release.
